// File: rtl/gshare_branch_predictor_if.sv
// Request/prediction and resolve/update bundle between decode, ALU and the gshare predictor.
// The master side (core) drives requests and updates; the slave side (predictor) returns the prediction.
interface gshare_branch_predictor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int GHR_BITS   = 8
);
  logic                  req_valid;
  logic                  req_is_jump;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [ADDR_WIDTH-1:0] req_target;
  logic [ADDR_WIDTH-1:0] req_fallthrough;

  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_target;
  logic [GHR_BITS-1:0]   pred_ghr;

  logic                  upd_valid;
  logic                  upd_is_jump;
  logic [ADDR_WIDTH-1:0] upd_pc;
  logic [GHR_BITS-1:0]   upd_ghr;
  logic                  upd_prediction;
  logic                  upd_outcome;

  modport master (
    output req_valid, req_is_jump, req_pc, req_target, req_fallthrough,
    output upd_valid, upd_is_jump, upd_pc, upd_ghr, upd_prediction, upd_outcome,
    input  pred_taken, pred_target, pred_ghr
  );

  modport slave (
    input  req_valid, req_is_jump, req_pc, req_target, req_fallthrough,
    input  upd_valid, upd_is_jump, upd_pc, upd_ghr, upd_prediction, upd_outcome,
    output pred_taken, pred_target, pred_ghr
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare conditional-branch predictor with speculative global history and mispredict repair.
// Optional macro BP_STATS_EN adds saturating branch/mispredict counters (stat_branches, stat_mispredicts).
module gshare_branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS   = 8,
  parameter int CTR_BITS   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gshare_branch_predictor_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]             stat_branches,
  output logic [31:0]             stat_mispredicts
`endif
);

  localparam int                  ENTRIES  = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  generate
    if (GHR_BITS > INDEX_BITS) begin : g_bad_ghr
      $error("GHR_BITS (%0d) must not exceed INDEX_BITS (%0d)", GHR_BITS, INDEX_BITS);
    end
    if (INDEX_BITS < 2 || INDEX_BITS > 12) begin : g_bad_index
      $error("INDEX_BITS (%0d) must be within 2..12", INDEX_BITS);
    end
    if (CTR_BITS < 1 || CTR_BITS > 4) begin : g_bad_ctr
      $error("CTR_BITS (%0d) must be within 1..4", CTR_BITS);
    end
    if (ADDR_WIDTH < INDEX_BITS + 2) begin : g_bad_addr
      $error("ADDR_WIDTH (%0d) too narrow for INDEX_BITS (%0d)", ADDR_WIDTH, INDEX_BITS);
    end
  endgenerate

  function automatic logic [INDEX_BITS-1:0] pht_index(
    input logic [ADDR_WIDTH-1:0] pc,
    input logic [GHR_BITS-1:0]   ghr
  );
    return pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  // Shifting a new outcome into history; the cast drops the oldest bit.
  function automatic logic [GHR_BITS-1:0] ghr_push(
    input logic [GHR_BITS-1:0] h,
    input logic                b
  );
    return GHR_BITS'({h, b});
  endfunction

  logic [CTR_BITS-1:0]   pht_q [ENTRIES];
  logic [GHR_BITS-1:0]   ghr_q;
  logic [GHR_BITS-1:0]   ghr_d;

  logic [INDEX_BITS-1:0] req_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [CTR_BITS-1:0]   req_ctr;
  logic [CTR_BITS-1:0]   upd_ctr_d;
  logic                  taken;
  logic                  train;
  logic                  mispredict;
  logic                  spec_shift;
  logic                  unused_pc_bits;

  assign req_idx    = pht_index(bp.req_pc, ghr_q);
  assign upd_idx    = pht_index(bp.upd_pc, bp.upd_ghr);
  assign req_ctr    = pht_q[req_idx];
  assign taken      = bp.req_valid & (bp.req_is_jump | req_ctr[CTR_BITS-1]);

  assign train      = bp.upd_valid & ~bp.upd_is_jump;
  assign mispredict = train & (bp.upd_prediction != bp.upd_outcome);
  assign spec_shift = bp.req_valid & ~bp.req_is_jump;
  assign upd_ctr_d  = bp.upd_outcome ? ctr_inc(pht_q[upd_idx]) : ctr_dec(pht_q[upd_idx]);

  assign bp.pred_taken  = taken;
  assign bp.pred_target = taken ? bp.req_target : bp.req_fallthrough;
  assign bp.pred_ghr    = bp.req_valid ? ghr_q : '0;

  assign unused_pc_bits = ^{bp.req_pc, bp.upd_pc};

  // A mispredict rebuilds history from the branch's own snapshot; the concurrent
  // request is younger and will be flushed, so its speculative bit is discarded.
  always_comb begin
    ghr_d = ghr_q;
    if (mispredict) begin
      ghr_d = ghr_push(bp.upd_ghr, bp.upd_outcome);
    end else if (spec_shift) begin
      ghr_d = ghr_push(ghr_q, taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= CTR_INIT;
      end
    end else begin
      ghr_q <= ghr_d;
      if (train) begin
        pht_q[upd_idx] <= upd_ctr_d;
      end
    end
  end

`ifdef BP_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stat_branches_q;
  logic [31:0] stat_branches_d;
  logic [31:0] stat_mispredicts_q;
  logic [31:0] stat_mispredicts_d;

  assign stat_branches_d    = train      ? sat_inc32(stat_branches_q)    : stat_branches_q;
  assign stat_mispredicts_d = mispredict ? sat_inc32(stat_mispredicts_q) : stat_mispredicts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor: reset, jumps, training/saturation, history shift, repair, async reset.
module tb_gshare_branch_predictor;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  gshare_branch_predictor_if #(.ADDR_WIDTH(32), .GHR_BITS(8)) bif ();

`ifdef BP_STATS_EN
  logic [31:0] stat_b;
  logic [31:0] stat_m;
`endif

  gshare_branch_predictor #(
    .ADDR_WIDTH(32),
    .INDEX_BITS(8),
    .GHR_BITS  (8),
    .CTR_BITS  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bp   (bif)
`ifdef BP_STATS_EN
    ,
    .stat_branches   (stat_b),
    .stat_mispredicts(stat_m)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic j, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [31:0] ft);
    bif.req_valid       = v;
    bif.req_is_jump     = j;
    bif.req_pc          = pc;
    bif.req_target      = tgt;
    bif.req_fallthrough = ft;
  endtask

  task automatic set_upd(input logic v, input logic j, input logic [31:0] pc,
                         input logic [7:0] ghr, input logic pr, input logic oc);
    bif.upd_valid      = v;
    bif.upd_is_jump    = j;
    bif.upd_pc         = pc;
    bif.upd_ghr        = ghr;
    bif.upd_prediction = pr;
    bif.upd_outcome    = oc;
  endtask

  // Lookup helper: drive a conditional request, settle, return to idle.
  task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken,
                      input logic [7:0] exp_ghr);
    set_req(1'b1, 1'b0, pc, 32'h200, 32'h108);
    #1;
    chk({tag, "_taken"}, 64'(bif.pred_taken), 64'(exp_taken));
    chk({tag, "_ghr"}, 64'(bif.pred_ghr), 64'(exp_ghr));
    set_req(1'b0, 1'b0, pc, 32'h200, 32'h108);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 32'h200, 32'h108);
    set_upd(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    chk("idle_taken", 64'(bif.pred_taken), 64'h0);
    chk("idle_target", 64'(bif.pred_target), 64'h108);
    rst_n = 1'b1;

    // Reset defaults.
    set_req(1'b1, 1'b0, 32'h100, 32'h200, 32'h108);
    #1;
    chk("rst_taken", 64'(bif.pred_taken), 64'h0);
    chk("rst_target", 64'(bif.pred_target), 64'h108);
    chk("rst_ghr", 64'(bif.pred_ghr), 64'h0);

    // Jump predicted taken and does not shift history.
    set_req(1'b1, 1'b1, 32'h100, 32'h400, 32'h108);
    #1;
    chk("jmp_taken", 64'(bif.pred_taken), 64'h1);
    chk("jmp_target", 64'(bif.pred_target), 64'h400);
    chk("jmp_ghr", 64'(bif.pred_ghr), 64'h0);
    tick();
    look("jmp_noshift", 32'h100, 1'b0, 8'h00);

    // First increment with same-index lookup: reads the pre-update counter (1).
    set_upd(1'b1, 1'b0, 32'h100, 8'h00, 1'b1, 1'b1);
    set_req(1'b1, 1'b0, 32'h100, 32'h200, 32'h108);
    #1;
    chk("same_idx_pre", 64'(bif.pred_taken), 64'h0);
    tick();
    set_req(1'b0, 1'b0, 32'h100, 32'h200, 32'h108);
    look("inc_to2", 32'h100, 1'b1, 8'h00);
    tick();
    tick();
    tick();
    set_upd(1'b0, 1'b0, 32'h100, 8'h00, 1'b0, 1'b0);
    look("inc_sat3", 32'h100, 1'b1, 8'h00);

    // Decrements 3 -> 2 -> 1 -> 0 -> 0, then increments 0 -> 1 -> 2.
    set_upd(1'b1, 1'b0, 32'h100, 8'h00, 1'b0, 1'b0);
    tick();
    look("dec_to2", 32'h100, 1'b1, 8'h00);
    tick();
    look("dec_to1", 32'h100, 1'b0, 8'h00);
    tick();
    tick();
    set_upd(1'b1, 1'b0, 32'h100, 8'h00, 1'b1, 1'b1);
    tick();
    look("sat_lo_to1", 32'h100, 1'b0, 8'h00);
    tick();
    set_upd(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    look("back_to2", 32'h100, 1'b1, 8'h00);

    // Speculative shift: predictions 1, 0, 1 -> GHR 0x05.
    set_req(1'b1, 1'b0, 32'h100, 32'h200, 32'h108);
    #1;
    chk("spec1_taken", 64'(bif.pred_taken), 64'h1);
    tick();
    set_req(1'b1, 1'b0, 32'h200, 32'h300, 32'h208);
    #1;
    chk("spec2_taken", 64'(bif.pred_taken), 64'h0);
    chk("spec2_ghr", 64'(bif.pred_ghr), 64'h01);
    tick();
    set_req(1'b1, 1'b0, 32'h108, 32'h500, 32'h110);
    #1;
    chk("spec3_taken", 64'(bif.pred_taken), 64'h1);
    chk("spec3_target", 64'(bif.pred_target), 64'h500);
    chk("spec3_ghr", 64'(bif.pred_ghr), 64'h02);
    tick();

    // Repair beats the concurrent speculative shift.
    set_req(1'b1, 1'b0, 32'h300, 32'h600, 32'h308);
    #1;
    chk("spec_ghr5", 64'(bif.pred_ghr), 64'h05);
    set_upd(1'b1, 1'b0, 32'h300, 8'h02, 1'b0, 1'b1);
    tick();
    set_upd(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    look("repair_prio", 32'h300, 1'b0, 8'h05);
    set_upd(1'b1, 1'b0, 32'h300, 8'h40, 1'b1, 1'b0);
    tick();
    set_upd(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    look("repair2", 32'h300, 1'b1, 8'h80);

    // Correct update alongside a request: normal shift only.
    set_req(1'b1, 1'b0, 32'h300, 32'h600, 32'h308);
    set_upd(1'b1, 1'b0, 32'h400, 8'h00, 1'b1, 1'b1);
    #1;
    chk("corr_taken", 64'(bif.pred_taken), 64'h1);
    tick();
    set_upd(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    set_req(1'b0, 1'b0, 32'h0, 32'h200, 32'h108);

    // Jump updates neither train nor repair.
    set_upd(1'b1, 1'b1, 32'h200, 8'h00, 1'b0, 1'b1);
    tick();
    tick();
    set_upd(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    look("jmp_upd_ign", 32'h204, 1'b0, 8'h01);

`ifdef BP_STATS_EN
    chk("stat_branches", 64'(stat_b), 64'd13);
    chk("stat_mispredicts", 64'(stat_m), 64'd2);
`endif

    // Asynchronous reset between clock edges.
    tick();
    set_req(1'b1, 1'b0, 32'h104, 32'h200, 32'h10C);
    #1;
    chk("pre_areset_taken", 64'(bif.pred_taken), 64'h1);
    rst_n = 1'b0;
    set_req(1'b1, 1'b0, 32'h100, 32'h200, 32'h108);
    #1;
    chk("areset_taken", 64'(bif.pred_taken), 64'h0);
    chk("areset_ghr", 64'(bif.pred_ghr), 64'h0);
    chk("areset_target", 64'(bif.pred_target), 64'h108);
`ifdef BP_STATS_EN
    chk("areset_stat_b", 64'(stat_b), 64'h0);
    chk("areset_stat_m", 64'(stat_m), 64'h0);
`endif
    rst_n = 1'b1;
    set_req(1'b0, 1'b0, 32'h100, 32'h200, 32'h108);

    // Counter came back as 1: a single increment makes it predict taken.
    tick();
    set_upd(1'b1, 1'b0, 32'h100, 8'h00, 1'b1, 1'b1);
    tick();
    set_upd(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    look("post_reset_inc", 32'h100, 1'b1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
